// File: rtl/serial_rx_deframer.sv
// One-wire serial byte receiver: high start bit, 8 data bits LSB first, low stop level.
// Define SERIAL_RX_SYNC_EN to add a 2-flop input synchronizer (+2 cycles latency).
module serial_rx_deframer #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_WAIT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] err_cnt,
  output logic [1:0] state_test,
  output logic [3:0] bit_cnt_test
);

  localparam int TW = $clog2(2 * CLKS_PER_BIT);
  localparam int SW = $clog2(STOP_WAIT + 1);
  // First sample lands mid-way through D0; later samples are one bit period apart.
  localparam logic [TW-1:0] FIRST_LOAD = TW'(CLKS_PER_BIT + (CLKS_PER_BIT - 1) / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD   = TW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_LAST  = SW'(STOP_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0] stop_cnt_q, stop_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          rx_s;
  logic          sample_s;

`ifdef SERIAL_RX_SYNC_EN
  logic sync1_q, sync2_q;

  // two-flop synchronizer for an asynchronous line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;
`else
  assign rx_s = rxd;
`endif

  assign sample_s = (timer_q == {TW{1'b0}});

  // next-state and output logic
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (rx_s) begin
          state_d   = DATA;
          timer_d   = FIRST_LOAD;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (sample_s) begin
          shift_d[bit_cnt_q[2:0]] = rx_s;
          timer_d   = BIT_LOAD;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            state_d    = STOP;
            stop_cnt_d = {SW{1'b0}};
          end else begin
            state_d = DATA;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      STOP: begin
        if (sample_s) begin
          timer_d = BIT_LOAD;
          if (!rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else if (stop_cnt_q == STOP_LAST) begin
            frame_err_d = 1'b1;
            err_cnt_d   = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
            state_d     = WAIT_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + SW'(1);
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WAIT_IDLE: begin
        // a line stuck high must not be mistaken for a new start bit
        if (!rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= {TW{1'b0}};
      bit_cnt_q   <= 4'd0;
      stop_cnt_q  <= {SW{1'b0}};
      shift_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign frame_err    = frame_err_q;
  assign busy         = busy_q;
  assign err_cnt      = err_cnt_q;
  assign state_test   = state_q;
  assign bit_cnt_test = bit_cnt_q;

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Directed bench for serial_rx_deframer; pulses are scoreboarded against predicted cycle and byte.
module tb_serial_rx_deframer;

`ifdef SERIAL_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b0;
  logic rxd4 = 1'b0;

  logic [7:0] data, err_cnt, data4, err_cnt4;
  logic       valid, frame_err, busy, valid4, frame_err4, busy4;
  logic [1:0] state_test, state_test4;
  logic [3:0] bit_cnt_test, bit_cnt_test4;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  typedef struct {
    int         cyc;
    logic       is_err;
    logic [7:0] byte_v;
  } exp_t;
  exp_t exp_q[$];

  serial_rx_deframer #(.CLKS_PER_BIT(1), .STOP_WAIT(2)) u_dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .frame_err(frame_err), .busy(busy), .err_cnt(err_cnt),
    .state_test(state_test), .bit_cnt_test(bit_cnt_test)
  );

  serial_rx_deframer #(.CLKS_PER_BIT(4), .STOP_WAIT(2)) u_dut4 (
    .clk(clk), .rst(rst), .rxd(rxd4), .data(data4), .valid(valid4),
    .frame_err(frame_err4), .busy(busy4), .err_cnt(err_cnt4),
    .state_test(state_test4), .bit_cnt_test(bit_cnt_test4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v);
    rxd = v;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int c, input logic e, input logic [7:0] b);
    exp_t x;
    x.cyc = c;
    x.is_err = e;
    x.byte_v = b;
    exp_q.push_back(x);
  endtask

  task automatic send_frame(input logic [7:0] b, input int d7_len, input int stop_len);
    drive(1'b1);
    for (int i = 0; i < 7; i++) drive(b[i]);
    repeat (d7_len) drive(b[7]);
    repeat (stop_len) drive(1'b0);
  endtask

  // Scoreboard: every pulse on the 1-cycle-per-bit receiver must match the queue head.
  always @(negedge clk) begin
    if (!rst && (valid || frame_err)) begin
      if (valid && frame_err) begin
        chk("pulse_overlap", {30'd0, valid, frame_err}, 32'd2);
      end else if (exp_q.size() == 0) begin
        chk("spurious_pulse", {30'd0, valid, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", cyc_cnt, e.cyc);
        chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        if (!e.is_err) chk("pulse_data", {24'd0, data}, {24'd0, e.byte_v});
      end
    end
  end

  initial begin
    int t0;
    logic got4;
    logic [7:0] b4;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_outputs", {data, valid, frame_err, busy, err_cnt, state_test, bit_cnt_test},
        32'd0);
    chk("rst_outputs4", {24'd0, data4, valid4, frame_err4, busy4}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) drive(1'b0);

    // Frame 0xA5 with single-cycle stop
    t0 = cyc_cnt;
    push_exp(t0 + 10 + LAT, 1'b0, 8'hA5);
    send_frame(8'hA5, 1, 1);
    repeat (3 + LAT) drive(1'b0);
    chk("t1_data", {24'd0, data}, 32'hA5);
    chk("t1_err_cnt", {24'd0, err_cnt}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // Frame 0x81 with stretched D7: second stop sample sees the low level
    t0 = cyc_cnt;
    push_exp(t0 + 11 + LAT, 1'b0, 8'h81);
    send_frame(8'h81, 2, 1);
    repeat (3 + LAT) drive(1'b0);
    chk("t2_data", {24'd0, data}, 32'h81);

    // 0xFF then line held high: framing error, data preserved
    t0 = cyc_cnt;
    push_exp(t0 + 11 + LAT, 1'b1, 8'h00);
    drive(1'b1);
    repeat (8) drive(1'b1);
    repeat (2) drive(1'b1);
    rxd = 1'b1;
    @(negedge clk);
    chk("t3_busy_high", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    repeat (LAT) drive(1'b1);
    @(negedge clk);
    chk("t3_busy_wait_idle", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    repeat (3 + LAT) drive(1'b0);
    chk("t3_err_cnt", {24'd0, err_cnt}, 32'd1);
    chk("t3_data_kept", {24'd0, data}, 32'h81);
    chk("t3_busy_done", {31'd0, busy}, 32'd0);

    // Reset mid-frame, then a clean 0x3C frame
    drive(1'b1);
    drive(1'b0);
    drive(1'b0);
    drive(1'b1);
    rst = 1'b1;
    drive(1'b0);
    @(negedge clk);
    chk("t4_rst_outputs", {data, valid, frame_err, busy, err_cnt, state_test, bit_cnt_test},
        32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3 + LAT) drive(1'b0);
    t0 = cyc_cnt;
    push_exp(t0 + 10 + LAT, 1'b0, 8'h3C);
    send_frame(8'h3C, 1, 1);
    repeat (3 + LAT) drive(1'b0);
    chk("t4_data", {24'd0, data}, 32'h3C);

    // Back-to-back frames with one low stop cycle between them
    t0 = cyc_cnt;
    push_exp(t0 + 10 + LAT, 1'b0, 8'h12);
    push_exp(t0 + 20 + LAT, 1'b0, 8'h34);
    send_frame(8'h12, 1, 1);
    send_frame(8'h34, 1, 1);
    repeat (3 + LAT) drive(1'b0);
    chk("t5_data", {24'd0, data}, 32'h34);

    // Four clocks per bit, frame 0x5A on the second receiver
    b4 = 8'h5A;
    got4 = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < 4) rxd4 = 1'b1;
      else if (i < 36) rxd4 = b4[(i - 4) / 4];
      else rxd4 = 1'b0;
      @(negedge clk);
      if (i == LAT + 5) begin
        chk("t6_d0_state", {30'd0, state_test4}, 32'd1);
        chk("t6_d0_bitcnt", {28'd0, bit_cnt_test4}, 32'd0);
      end
      if (i == LAT + 6) chk("t6_d0_sampled", {28'd0, bit_cnt_test4}, 32'd1);
      if (valid4) begin
        got4 = 1'b1;
        chk("t6_data", {24'd0, data4}, 32'h5A);
      end
      if (frame_err4) chk("t6_frame_err", {31'd0, frame_err4}, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("t6_valid_seen", {31'd0, got4}, 32'd1);

    // Error counter saturation
    for (int k = 0; k < 256; k++) begin
      t0 = cyc_cnt;
      push_exp(t0 + 11 + LAT, 1'b1, 8'h00);
      repeat (11) drive(1'b1);
      repeat (3 + LAT) drive(1'b0);
    end
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    chk("sat_data_kept", {24'd0, data}, 32'h34);

    repeat (4) drive(1'b0);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
